// File: rtl/spi_alu_slave_p.sv
// spi_alu_slave_p: SPI slave that receives opcode + two W-bit operands, runs one ALU op
// and shifts the W-bit result plus CF/VF/SF/ZF back out in the same chip-select frame.
module spi_alu_slave_p #(
  parameter int W         = 8,
  parameter int OPW       = 4,
  parameter int LSB_FIRST = 0
) (
  input  logic i_sclk,
  input  logic i_rst,
  input  logic i_cs,
  input  logic i_mosi,
  output logic o_miso
);
  localparam int CW = $clog2(W + 5);
  typedef enum logic [2:0] {IDLE, RX_OP, RX_A, RX_B, EXEC, TX, DONE} state_t;
  state_t r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [OPW-1:0] r_op, w_op, w_op_sh;
  logic [W-1:0] r_a, w_a, w_a_sh, r_b, w_b, w_b_sh;
  logic [W-1:0] w_res, w_out, w_ord;
  logic [W+3:0] r_tx, w_tx, w_pkt;
  logic [W:0] w_sum, w_dif, w_shl, w_shr;
  logic [3:0] w_flags;
  logic w_cf, w_vf, w_big, w_bad, r_miso, w_miso;
  assign w_op_sh = LSB_FIRST ? {i_mosi, r_op[OPW-1:1]} : {r_op[OPW-2:0], i_mosi};
  assign w_a_sh  = LSB_FIRST ? {i_mosi, r_a[W-1:1]} : {r_a[W-2:0], i_mosi};
  assign w_b_sh  = LSB_FIRST ? {i_mosi, r_b[W-1:1]} : {r_b[W-2:0], i_mosi};
  assign w_sum = {1'b0, r_a} + {1'b0, r_b};
  assign w_dif = {1'b0, r_a} - {1'b0, r_b};
  assign w_shl = {1'b0, r_a} << r_b;
  assign w_shr = {r_a, 1'b0} >> r_b;
  // the whole of B is range-checked so any amount >= W flushes to zero
  assign w_big = {1'b0, r_b} >= (W + 1)'(W);
  assign w_bad = (r_op >> 3) != '0;
  always_comb begin
    w_res = '0;
    w_cf  = 1'b0;
    w_vf  = 1'b0;
    case (r_op[2:0])
      3'd0: begin
        w_res = w_sum[W-1:0];
        w_cf  = w_sum[W];
        w_vf  = (r_a[W-1] == r_b[W-1]) && (w_sum[W-1] != r_a[W-1]);
      end
      3'd1: begin
        w_res = w_dif[W-1:0];
        w_cf  = w_dif[W];
        w_vf  = (r_a[W-1] != r_b[W-1]) && (w_dif[W-1] != r_a[W-1]);
      end
      3'd2: w_res = r_a & r_b;
      3'd3: w_res = r_a | r_b;
      3'd4: w_res = r_a ^ r_b;
      3'd5: w_res = ~r_a;
      3'd6: begin
        w_res = w_big ? '0 : w_shl[W-1:0];
        w_cf  = !w_big && w_shl[W];
      end
      3'd7: begin
        w_res = w_big ? '0 : w_shr[W:1];
        w_cf  = !w_big && w_shr[0];
      end
    endcase
  end
  // result 0 with all four flags set cannot arise from a valid op: it marks a bad opcode
  assign w_out   = w_bad ? '0 : w_res;
  assign w_flags = w_bad ? 4'hF : {w_cf, w_vf, w_res[W-1], w_res == '0};
  always_comb begin
    w_ord = '0;
    for (int i = 0; i < W; i++) w_ord[i] = LSB_FIRST ? w_out[W-1-i] : w_out[i];
  end
  // packet is stored in transmit order and always shifted out from the top
  assign w_pkt = {w_ord, w_flags};
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_op    = r_op;
    w_a     = r_a;
    w_b     = r_b;
    w_tx    = r_tx;
    w_miso  = 1'b0;
    if (i_cs) begin
      w_state = IDLE;
      w_cnt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_op    = w_op_sh;
          w_state = RX_OP;
          w_cnt   = CW'(1);
        end
        RX_OP: begin
          w_op    = w_op_sh;
          w_state = (r_cnt == CW'(OPW - 1)) ? RX_A : RX_OP;
          w_cnt   = (r_cnt == CW'(OPW - 1)) ? '0 : r_cnt + 1'b1;
        end
        RX_A: begin
          w_a     = w_a_sh;
          w_state = (r_cnt == CW'(W - 1)) ? RX_B : RX_A;
          w_cnt   = (r_cnt == CW'(W - 1)) ? '0 : r_cnt + 1'b1;
        end
        RX_B: begin
          w_b     = w_b_sh;
          w_state = (r_cnt == CW'(W - 1)) ? EXEC : RX_B;
          w_cnt   = (r_cnt == CW'(W - 1)) ? '0 : r_cnt + 1'b1;
        end
        EXEC: begin
          w_tx    = w_pkt;
          w_miso  = w_pkt[W+3];
          w_cnt   = CW'(1);
          w_state = TX;
        end
        TX: begin
          if (r_cnt == CW'(W + 4)) begin
            w_state = DONE;
            w_cnt   = '0;
          end else begin
            w_tx   = r_tx << 1;
            w_miso = r_tx[W+2];
            w_cnt  = r_cnt + 1'b1;
          end
        end
        DONE: w_state = DONE;
        default: w_state = IDLE;
      endcase
    end
  end
  always_ff @(posedge i_sclk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_tx    <= '0;
      r_miso  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_op    <= w_op;
      r_a     <= w_a;
      r_b     <= w_b;
      r_tx    <= w_tx;
      r_miso  <= w_miso;
    end
  end
  assign o_miso = r_miso;
endmodule
